// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, bubble encoding, reset PC and
// instruction field positions used by fetch and decode.
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013; // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Field positions decode slices out of instr_d.
  localparam int OP_MSB       = 6;
  localparam int OP_LSB       = 0;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT7B5_BIT = 30;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            misalign;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: clr (flush) > !en (stall) > bubble > load.
// Flush and bubble both replace the instruction with a NOP but keep the PC
// fields, so decode still sees the PC of the last real instruction.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = pipeline_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  input  logic   bubble,
  input  if_id_t data_i,
  output if_id_t data_o
);

  if_id_t data_q;
  if_id_t data_d;

  // Next-state selection following the flush/stall/bubble priority.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d.instr    = NOP;
      data_d.valid    = 1'b0;
      data_d.misalign = 1'b0;
    end else if (!en) begin
      data_d = data_q;
    end else if (bubble) begin
      data_d.instr    = NOP;
      data_d.valid    = 1'b0;
      data_d.misalign = 1'b0;
    end else begin
      data_d = data_i;
    end
  end

  // Register with asynchronous reset to an empty (bubble) slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q.instr    <= NOP;
      data_q.pc       <= '0;
      data_q.pc_plus4 <= '0;
      data_q.valid    <= 1'b0;
      data_q.misalign <= 1'b0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux with EX redirect, and the
// IF/ID register feeding decode. Redirect targets are forced word-aligned;
// a misaligned target is remembered and tagged onto the instruction fetched
// from it.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = pipeline_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            misalign_d
);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            misalign_f_q, misalign_f_d;
  logic [XLEN-1:0] pc_plus4_f;
  logic            capture;
  if_id_t          if_id_in;
  if_id_t          if_id_out;

  assign pc_plus4_f = pc_f_q + 32'd4;

  // The fetch at pc_f is accepted into IF/ID only on a plain load cycle.
  assign capture = !flush_d && !stall_d && imem_ready && !pc_src_e;

  // Next PC: redirect beats stall and memory wait; otherwise advance by 4.
  always_comb begin
    pc_f_d = pc_f_q;
    if (pc_src_e) begin
      pc_f_d = {pc_target_e[XLEN-1:2], 2'b00};
    end else if (stall_f || !imem_ready) begin
      pc_f_d = pc_f_q;
    end else begin
      pc_f_d = pc_plus4_f;
    end
  end

  // Misalign flag follows the latest redirect until its fetch is captured.
  always_comb begin
    misalign_f_d = misalign_f_q;
    if (pc_src_e) begin
      misalign_f_d = |pc_target_e[1:0];
    end else if (capture) begin
      misalign_f_d = 1'b0;
    end
  end

  // PC and misalign state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q       <= RESET_PC;
      misalign_f_q <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      misalign_f_q <= misalign_f_d;
    end
  end

  assign if_id_in.instr    = imem_rd;
  assign if_id_in.pc       = pc_f_q;
  assign if_id_in.pc_plus4 = pc_plus4_f;
  assign if_id_in.valid    = 1'b1;
  assign if_id_in.misalign = misalign_f_q;

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (!stall_d),
    .clr    (flush_d),
    .bubble (!imem_ready || pc_src_e),
    .data_i (if_id_in),
    .data_o (if_id_out)
  );

  assign pc_f       = pc_f_q;
  assign imem_addr  = pc_f_q;
  assign instr_d    = if_id_out.instr;
  assign pc_d       = if_id_out.pc;
  assign pc_plus4_d = if_id_out.pc_plus4;
  assign valid_d    = if_id_out.valid;
  assign misalign_d = if_id_out.misalign;

endmodule
